// File: rtl/imul_sequential.sv
// Sequential shift-and-add integer multiplier, DIGIT multiplier bits per cycle.
// Signed products use sign-magnitude: unsigned core on |a|,|b|, then a final conditional negate.
module imul_sequential #(
    parameter int unsigned NB    = 16,
    parameter int unsigned DIGIT = 2
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iStart,
    input  logic            iSigned,
    input  logic [NB-1:0]   iA,
    input  logic [NB-1:0]   iB,
    output logic            oBusy,
    output logic            oDone,
    output logic [2*NB-1:0] oResult
);

    localparam int unsigned N  = NB / DIGIT;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * NB;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [NB-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   result_q, result_d;
    logic            neg_q, neg_d;
    logic [KW-1:0]   k_q, k_d;

    logic [NB-1:0]   mag_a, mag_b;
    logic [PW-1:0]   row, acc_sum;
    logic            capture, last;

    // Magnitudes; |-2^(NB-1)| wraps to itself, which is the correct unsigned value.
    assign mag_a = (iSigned && iA[NB-1]) ? (-iA) : iA;
    assign mag_b = (iSigned && iB[NB-1]) ? (-iB) : iB;

    // mcand_q already carries the k*DIGIT shift; mplier_q low bits are the current digit.
    always_comb begin
        row = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (mplier_q[j]) begin
                row = row + (mcand_q << j);
            end
        end
    end

    assign acc_sum = acc_q + row;
    assign last    = (k_q == KW'(N - 1));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        neg_d    = neg_q;
        k_d      = k_q;
        capture  = 1'b0;

        case (state_q)
            StIdle: begin
                capture = iStart;
            end
            StRun: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << DIGIT;
                mplier_d = mplier_q >> DIGIT;
                k_d      = k_q + 1'b1;
                if (last) begin
                    state_d  = StDone;
                    result_d = neg_q ? (-acc_sum) : acc_sum;
                    k_d      = '0;
                end
            end
            StDone: begin
                capture = iStart;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            state_d  = StRun;
            mcand_d  = {{NB{1'b0}}, mag_a};
            mplier_d = mag_b;
            neg_d    = iSigned & (iA[NB-1] ^ iB[NB-1]);
            acc_d    = '0;
            k_d      = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            k_q      <= k_d;
        end
    end

    assign oBusy   = (state_q == StRun);
    assign oDone   = (state_q == StDone);
    assign oResult = result_q;

endmodule

// File: tb/tb_imul_sequential.sv
// Directed and randomised checks of imul_sequential: table vectors, handshake corner cases,
// and a parameter sweep over several DIGIT/NB combinations against a behavioural product.
module tb_imul_sequential;

    logic        clk = 1'b0;
    logic        rst, start, sgn;
    logic [15:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    logic        sw_start, sw_sgn;
    logic [15:0] sw_a, sw_b;
    logic        b1, d1, b4, d4, b16, d16;
    logic [31:0] r1, r4, r16;

    logic        n8_start, n8_sgn;
    logic [7:0]  n8_a, n8_b;
    logic        n8_busy, n8_done;
    logic [15:0] n8_res;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    imul_sequential #(.NB(16), .DIGIT(2)) dut (
        .Clock(clk), .Reset(rst), .iStart(start), .iSigned(sgn), .iA(a), .iB(b),
        .oBusy(busy), .oDone(done), .oResult(result)
    );
    imul_sequential #(.NB(16), .DIGIT(1)) dut_d1 (
        .Clock(clk), .Reset(rst), .iStart(sw_start), .iSigned(sw_sgn), .iA(sw_a), .iB(sw_b),
        .oBusy(b1), .oDone(d1), .oResult(r1)
    );
    imul_sequential #(.NB(16), .DIGIT(4)) dut_d4 (
        .Clock(clk), .Reset(rst), .iStart(sw_start), .iSigned(sw_sgn), .iA(sw_a), .iB(sw_b),
        .oBusy(b4), .oDone(d4), .oResult(r4)
    );
    imul_sequential #(.NB(16), .DIGIT(16)) dut_d16 (
        .Clock(clk), .Reset(rst), .iStart(sw_start), .iSigned(sw_sgn), .iA(sw_a), .iB(sw_b),
        .oBusy(b16), .oDone(d16), .oResult(r16)
    );
    imul_sequential #(.NB(8), .DIGIT(2)) dut_n8 (
        .Clock(clk), .Reset(rst), .iStart(n8_start), .iSigned(n8_sgn), .iA(n8_a), .iB(n8_b),
        .oBusy(n8_busy), .oDone(n8_done), .oResult(n8_res)
    );

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input bit s, input int nb, input logic [31:0] x,
                                            input logic [31:0] y);
        longint xv, yv, p;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[nb-1]) xv = xv - (longint'(1) << nb);
        if (s && y[nb-1]) yv = yv - (longint'(1) << nb);
        p = xv * yv;
        return 64'(p) & ((64'd1 << (2 * nb)) - 64'd1);
    endfunction

    // Start one op; lat is the cycle index (1 = cycle after the start edge) where oDone shows.
    task automatic run_op(input bit s, input logic [15:0] x, input logic [15:0] y,
                          output logic [31:0] res, output int lat, output int bcnt);
        sgn   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        res   = result;
        for (int c = 1; c <= 30; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] res, res1, res2;
        int lat, bcnt, ndone, c1, c2;
        int l1, l4, l16, l8;
        logic [31:0] e16;
        logic [15:0] e8;

        vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[2] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[3] = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
        vecs[4] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[5] = '{1'b0, 16'h1234, 16'h5678, 32'h06260060};
        vecs[6] = '{1'b1, 16'h0000, 16'hFFFF, 32'h00000000};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[8] = '{1'b0, 16'hFFFD, 16'h0005, 32'h0004FFF1};
        vecs[9] = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        sw_start = 1'b0; sw_sgn = 1'b0; sw_a = '0; sw_b = '0;
        n8_start = 1'b0; n8_sgn = 1'b0; n8_a = '0; n8_b = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat, bcnt);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd8);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_result_held", i), 64'(result), 64'(vecs[i].exp));
        end

        // iStart while busy must be ignored.
        sgn = 1'b0; a = 16'd3; b = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; c1 = 0; res1 = '0;
        for (int c = 1; c <= 25; c++) begin
            if (done) begin
                ndone++;
                if (c1 == 0) begin
                    c1   = c;
                    res1 = result;
                end
            end
            if (c >= 2 && c <= 5) begin
                start = 1'b1; a = 16'd9; b = 16'd9;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("busy_start_ndone", 64'(ndone), 64'd1);
        check("busy_start_latency", 64'(c1), 64'd9);
        check("busy_start_result", 64'(res1), 64'h0000000C);

        // Reset mid-operation.
        sgn = 1'b0; a = 16'h1234; b = 16'h5678; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) ndone++;
            tick();
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        run_op(1'b0, 16'h1234, 16'h5678, res, lat, bcnt);
        check("midrst_fresh_result", 64'(res), 64'h06260060);
        check("midrst_fresh_latency", 64'(lat), 64'd9);
        tick();

        // Back-to-back with iStart held high.
        sgn = 1'b0; a = 16'd2; b = 16'd3; start = 1'b1;
        tick();
        a = 16'd5; b = 16'd7;
        c1 = 0; c2 = 0; res1 = '0; res2 = '0;
        for (int c = 1; c <= 25; c++) begin
            if (done) begin
                if (c1 == 0) begin
                    c1 = c; res1 = result;
                end else if (c2 == 0) begin
                    c2 = c; res2 = result;
                end
            end
            if (c >= 10) start = 1'b0;
            tick();
        end
        check("b2b_first_cycle", 64'(c1), 64'd9);
        check("b2b_first_result", 64'(res1), 64'd6);
        check("b2b_second_cycle", 64'(c2), 64'd18);
        check("b2b_second_result", 64'(res2), 64'd35);

        // Sweep DIGIT = 1, 4, 16 at NB = 16.
        for (int it = 0; it < 1000; it++) begin
            sw_sgn = 1'($urandom);
            sw_a   = (it % 16 == 0) ? 16'h8000 : 16'($urandom);
            sw_b   = (it % 16 == 3) ? 16'hFFFF : 16'($urandom);
            e16    = 32'(ref_mul(sw_sgn, 16, {16'h0, sw_a}, {16'h0, sw_b}));
            sw_start = 1'b1;
            tick();
            sw_start = 1'b0;
            l1 = 0; l4 = 0; l16 = 0;
            check("sweep16_busy", 64'({b1, b4, b16}), 64'b111);
            for (int c = 1; c <= 20; c++) begin
                if (d1 && l1 == 0) begin
                    l1 = c;
                    check("sweep_d1_result", 64'(r1), 64'(e16));
                end
                if (d4 && l4 == 0) begin
                    l4 = c;
                    check("sweep_d4_result", 64'(r4), 64'(e16));
                end
                if (d16 && l16 == 0) begin
                    l16 = c;
                    check("sweep_d16_result", 64'(r16), 64'(e16));
                end
                if (l1 != 0 && l4 != 0 && l16 != 0) break;
                tick();
            end
            check("sweep_d1_latency", 64'(l1), 64'd17);
            check("sweep_d4_latency", 64'(l4), 64'd5);
            check("sweep_d16_latency", 64'(l16), 64'd2);
            tick();
        end

        // NB = 8, DIGIT = 2.
        for (int it = 0; it < 500; it++) begin
            n8_sgn = 1'($urandom);
            n8_a   = (it % 16 == 0) ? 8'h80 : 8'($urandom);
            n8_b   = (it % 16 == 5) ? 8'h80 : 8'($urandom);
            e8     = 16'(ref_mul(n8_sgn, 8, {24'h0, n8_a}, {24'h0, n8_b}));
            n8_start = 1'b1;
            tick();
            n8_start = 1'b0;
            l8 = 0;
            check("sweep_n8_busy", 64'(n8_busy), 64'd1);
            for (int c = 1; c <= 12; c++) begin
                if (n8_done) begin
                    l8 = c;
                    check("sweep_n8_result", 64'(n8_res), 64'(e8));
                    break;
                end
                tick();
            end
            check("sweep_n8_latency", 64'(l8), 64'd5);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
